// File: rtl/battleship_scorer.sv
// battleship_scorer: sequential battleship shot scorer. Holds a fleet of up to
// NUM_SHIPS ships, scores shots over a valid/ready handshake and tracks shot
// history, per-ship damage, sunk ships and game-over.
// Optional feature macro: BATTLESHIP_SHOT_LIMIT_EN (game ends after MAX_SHOTS
// scored shots).
//
// state | meaning
// ------+-----------------------------------------------------------
// SETUP | ship slots writable; Start validates the fleet
// PLAY  | shots accepted and scored, one per cycle
// DONE  | game over; Start returns to SETUP keeping the ship slots
module battleship_scorer #(
  parameter int BOARD_DIM = 10,
  parameter int COORD_W   = 4,
  parameter int NUM_SHIPS = 5,
  parameter int MAX_SHOTS = 50,
  localparam int IDX_W    = (NUM_SHIPS > 1) ? $clog2(NUM_SHIPS) : 1,
  localparam int SHOT_W   = $clog2(BOARD_DIM * BOARD_DIM + 1)
) (
  input  logic               clock,
  input  logic               reset_L,
  input  logic               ShipLoad,
  input  logic [IDX_W-1:0]   ShipIdx,
  input  logic [COORD_W-1:0] ShipX,
  input  logic [COORD_W-1:0] ShipY,
  input  logic [2:0]         ShipLen,
  input  logic               ShipVert,
  input  logic               Start,
  input  logic               ShotValid,
  input  logic [COORD_W-1:0] ShotX,
  input  logic [COORD_W-1:0] ShotY,
  output logic               ShotReady,
  output logic               ResultValid,
  output logic               Hit,
  output logic               NearMiss,
  output logic               Miss,
  output logic               Repeat,
  output logic               Wrong,
  output logic               Sunk,
  output logic [IDX_W-1:0]   SunkIdx,
  output logic [6:0]         NumHits,
  output logic [SHOT_W-1:0]  NumShots,
  output logic [IDX_W:0]     ShipsSunk,
  output logic [2:0]         BiggestShipSunk,
  output logic               ConfigError,
  output logic               GameOver
);

  localparam int CELLS = BOARD_DIM * BOARD_DIM;
  localparam int MAP_W = (CELLS > 1) ? $clog2(CELLS) : 1;

`ifdef BATTLESHIP_SHOT_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_SETUP, S_PLAY, S_DONE} state_t;

  state_t             state;
  logic [COORD_W-1:0] ship_x    [NUM_SHIPS];
  logic [COORD_W-1:0] ship_y    [NUM_SHIPS];
  logic [2:0]         ship_len  [NUM_SHIPS];
  logic               ship_vert [NUM_SHIPS];
  logic [2:0]         hit_cnt   [NUM_SHIPS];
  logic [CELLS-1:0]   shot_map;

  logic               cfg_ok;
  logic [IDX_W:0]     ships_used;
  logic               shot_wrong;
  logic               shot_repeat;
  logic               shot_hit;
  logic               shot_near;
  logic               sunk_now;
  logic [MAP_W-1:0]   cell_idx;
  logic [IDX_W-1:0]   hit_idx;
  logic [2:0]         hit_len;
  logic [2:0]         hit_cnt_cur;
  logic [SHOT_W-1:0]  shots_inc;
  logic [6:0]         hits_inc;
  logic [IDX_W:0]     sunk_inc;

  // True when cell (cx,cy) lies on the ship with bow (sx,sy); len 0 never covers.
  function automatic logic covers(input int sx, input int sy, input int len,
                                  input logic vert, input int cx, input int cy);
    if (vert) return (cx == sx) && (cy >= sy) && (cy < sy + len);
    else      return (cy == sy) && (cx >= sx) && (cx < sx + len);
  endfunction

  // Fleet legality: every ship on the board, no shared cells, at least one ship.
  always_comb begin
    logic any_ship;
    logic off_board;
    logic overlap;
    int   cx;
    int   cy;
    int   tail;
    any_ship  = 1'b0;
    off_board = 1'b0;
    overlap   = 1'b0;
    cx        = 0;
    cy        = 0;
    tail      = 0;
    for (int i = 0; i < NUM_SHIPS; i++) begin
      if (ship_len[i] != 3'd0) begin
        any_ship = 1'b1;
        tail = (ship_vert[i] ? int'(ship_y[i]) : int'(ship_x[i])) + int'(ship_len[i]) - 1;
        if (int'(ship_x[i]) >= BOARD_DIM || int'(ship_y[i]) >= BOARD_DIM || tail >= BOARD_DIM)
          off_board = 1'b1;
      end
    end
    for (int i = 0; i < NUM_SHIPS; i++) begin
      for (int j = i + 1; j < NUM_SHIPS; j++) begin
        for (int k = 0; k < 7; k++) begin
          if (k < int'(ship_len[i])) begin
            cx = int'(ship_x[i]) + (ship_vert[i] ? 0 : k);
            cy = int'(ship_y[i]) + (ship_vert[i] ? k : 0);
            if (covers(int'(ship_x[j]), int'(ship_y[j]), int'(ship_len[j]), ship_vert[j], cx, cy))
              overlap = 1'b1;
          end
        end
      end
    end
    cfg_ok = any_ship && !off_board && !overlap;
  end

  // Number of non-empty slots; the game ends when this many ships are sunk.
  always_comb begin
    ships_used = '0;
    for (int i = 0; i < NUM_SHIPS; i++)
      if (ship_len[i] != 3'd0) ships_used = ships_used + (IDX_W+1)'(1);
  end

  // Classify the offered shot against the fleet and shot history.
  always_comb begin
    int sx;
    int sy;
    sx          = int'(ShotX);
    sy          = int'(ShotY);
    shot_wrong  = (sx >= BOARD_DIM) || (sy >= BOARD_DIM);
    cell_idx    = MAP_W'(sy * BOARD_DIM + sx);
    shot_repeat = !shot_wrong && shot_map[cell_idx];
    shot_hit    = 1'b0;
    shot_near   = 1'b0;
    hit_idx     = '0;
    hit_len     = '0;
    hit_cnt_cur = '0;
    for (int i = 0; i < NUM_SHIPS; i++) begin
      if (covers(int'(ship_x[i]), int'(ship_y[i]), int'(ship_len[i]), ship_vert[i], sx, sy)) begin
        shot_hit    = 1'b1;
        hit_idx     = IDX_W'(i);
        hit_len     = ship_len[i];
        hit_cnt_cur = hit_cnt[i];
      end
      if (covers(int'(ship_x[i]), int'(ship_y[i]), int'(ship_len[i]), ship_vert[i], sx - 1, sy) ||
          covers(int'(ship_x[i]), int'(ship_y[i]), int'(ship_len[i]), ship_vert[i], sx + 1, sy) ||
          covers(int'(ship_x[i]), int'(ship_y[i]), int'(ship_len[i]), ship_vert[i], sx, sy - 1) ||
          covers(int'(ship_x[i]), int'(ship_y[i]), int'(ship_len[i]), ship_vert[i], sx, sy + 1))
        shot_near = 1'b1;
    end
    sunk_now  = shot_hit && (hit_cnt_cur + 3'd1 == hit_len);
    shots_inc = (NumShots == '1) ? NumShots : NumShots + SHOT_W'(1);
    hits_inc  = (NumHits == '1) ? NumHits : NumHits + 7'd1;
    sunk_inc  = (ShipsSunk == '1) ? ShipsSunk : ShipsSunk + (IDX_W+1)'(1);
  end

  assign ShotReady = (state == S_PLAY);
  assign GameOver  = (state == S_DONE);

  // Game FSM, fleet storage, shot history, counters and registered results.
  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state           <= S_SETUP;
      shot_map        <= '0;
      ResultValid     <= 1'b0;
      Hit             <= 1'b0;
      NearMiss        <= 1'b0;
      Miss            <= 1'b0;
      Repeat          <= 1'b0;
      Wrong           <= 1'b0;
      Sunk            <= 1'b0;
      SunkIdx         <= '0;
      NumHits         <= '0;
      NumShots        <= '0;
      ShipsSunk       <= '0;
      BiggestShipSunk <= '0;
      ConfigError     <= 1'b0;
      for (int i = 0; i < NUM_SHIPS; i++) begin
        ship_x[i]    <= '0;
        ship_y[i]    <= '0;
        ship_len[i]  <= '0;
        ship_vert[i] <= 1'b0;
        hit_cnt[i]   <= '0;
      end
    end else begin
      ResultValid <= 1'b0;
      Hit         <= 1'b0;
      NearMiss    <= 1'b0;
      Miss        <= 1'b0;
      Repeat      <= 1'b0;
      Wrong       <= 1'b0;
      Sunk        <= 1'b0;
      SunkIdx     <= '0;
      case (state)
        S_SETUP: begin
          if (ShipLoad && int'(ShipIdx) < NUM_SHIPS) begin
            ship_x[ShipIdx]    <= ShipX;
            ship_y[ShipIdx]    <= ShipY;
            ship_len[ShipIdx]  <= ShipLen;
            ship_vert[ShipIdx] <= ShipVert;
          end
          if (Start) begin
            if (cfg_ok) begin
              state       <= S_PLAY;
              ConfigError <= 1'b0;
            end else begin
              ConfigError <= 1'b1;
            end
          end
        end
        S_PLAY: begin
          if (ShotValid) begin
            ResultValid <= 1'b1;
            if (shot_wrong) begin
              Wrong <= 1'b1;
            end else begin
              NumShots <= shots_inc;
              if (shot_repeat) begin
                Repeat <= 1'b1;
              end else begin
                shot_map[cell_idx] <= 1'b1;
                if (shot_hit) begin
                  Hit              <= 1'b1;
                  NumHits          <= hits_inc;
                  hit_cnt[hit_idx] <= hit_cnt_cur + 3'd1;
                  if (sunk_now) begin
                    Sunk      <= 1'b1;
                    SunkIdx   <= hit_idx;
                    ShipsSunk <= sunk_inc;
                    if (hit_len > BiggestShipSunk) BiggestShipSunk <= hit_len;
                    if (sunk_inc == ships_used) state <= S_DONE;
                  end
                end else if (shot_near) begin
                  NearMiss <= 1'b1;
                end else begin
                  Miss <= 1'b1;
                end
              end
              if (LIMIT_EN && int'(shots_inc) >= MAX_SHOTS) state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (Start) begin
            state           <= S_SETUP;
            shot_map        <= '0;
            NumHits         <= '0;
            NumShots        <= '0;
            ShipsSunk       <= '0;
            BiggestShipSunk <= '0;
            for (int i = 0; i < NUM_SHIPS; i++) hit_cnt[i] <= '0;
          end
        end
        default: state <= S_SETUP;
      endcase
    end
  end

endmodule

// File: tb/tb_battleship_scorer.sv
`timescale 1ns/1ps
module tb_battleship_scorer;
  localparam int BD = 10;
  localparam int CW = 4;
  localparam int NS = 5;
  localparam int IW = 3;
  localparam int SW = 7;
`ifdef BATTLESHIP_SHOT_LIMIT_EN
  localparam int MS = 3;
`else
  localparam int MS = 50;
`endif

  logic          clock = 1'b0;
  logic          reset_L = 1'b0;
  logic          ShipLoad = 1'b0;
  logic [IW-1:0] ShipIdx = '0;
  logic [CW-1:0] ShipX = '0;
  logic [CW-1:0] ShipY = '0;
  logic [2:0]    ShipLen = '0;
  logic          ShipVert = 1'b0;
  logic          Start = 1'b0;
  logic          ShotValid = 1'b0;
  logic [CW-1:0] ShotX = '0;
  logic [CW-1:0] ShotY = '0;
  logic          ShotReady, ResultValid, Hit, NearMiss, Miss, Repeat, Wrong, Sunk;
  logic [IW-1:0] SunkIdx;
  logic [6:0]    NumHits;
  logic [SW-1:0] NumShots;
  logic [IW:0]   ShipsSunk;
  logic [2:0]    BiggestShipSunk;
  logic          ConfigError, GameOver;

  battleship_scorer #(.BOARD_DIM(BD), .COORD_W(CW), .NUM_SHIPS(NS), .MAX_SHOTS(MS)) dut (
    .clock(clock), .reset_L(reset_L), .ShipLoad(ShipLoad), .ShipIdx(ShipIdx),
    .ShipX(ShipX), .ShipY(ShipY), .ShipLen(ShipLen), .ShipVert(ShipVert),
    .Start(Start), .ShotValid(ShotValid), .ShotX(ShotX), .ShotY(ShotY),
    .ShotReady(ShotReady), .ResultValid(ResultValid), .Hit(Hit), .NearMiss(NearMiss),
    .Miss(Miss), .Repeat(Repeat), .Wrong(Wrong), .Sunk(Sunk), .SunkIdx(SunkIdx),
    .NumHits(NumHits), .NumShots(NumShots), .ShipsSunk(ShipsSunk),
    .BiggestShipSunk(BiggestShipSunk), .ConfigError(ConfigError), .GameOver(GameOver)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          hit, near, miss, rep, wrong, sunk;
    logic [IW-1:0] sidx;
    logic [6:0]    hits;
    logic [SW-1:0] shots;
    logic [IW:0]   ships;
    logic [2:0]    big;
    logic          over, ready;
  } res_t;

  int   n_total = 0;
  int   n_pass  = 0;
  int   pcyc    = 0;
  res_t exp_q[$];
  int   exp_t[$];

  // Reference game model: slots, board occupancy grid and plain counters.
  int s_x[NS], s_y[NS], s_len[NS], s_vert[NS];
  int occ[BD][BD];
  bit shot_m[BD][BD];
  int hit_per[NS];
  int m_hits, m_shots, m_sunk, m_big, m_nships, m_state;  // state 0 setup,1 play,2 done
  bit m_cfg_err;
  int tgt_x[$], tgt_y[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic bit occupied(input int x, input int y);
    if (x < 0 || y < 0 || x >= BD || y >= BD) return 1'b0;
    return occ[x][y] >= 0;
  endfunction

  task automatic clear_game();
    for (int x = 0; x < BD; x++) for (int y = 0; y < BD; y++) shot_m[x][y] = 1'b0;
    for (int s = 0; s < NS; s++) hit_per[s] = 0;
    m_hits = 0; m_shots = 0; m_sunk = 0; m_big = 0;
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin s_x[s] = 0; s_y[s] = 0; s_len[s] = 0; s_vert[s] = 0; end
    for (int x = 0; x < BD; x++) for (int y = 0; y < BD; y++) occ[x][y] = -1;
    clear_game();
    m_state = 0; m_cfg_err = 1'b0; m_nships = 0;
    tgt_x.delete(); tgt_y.delete();
  endtask

  task automatic model_start();
    bit ok;
    bit any;
    int cx, cy;
    if (m_state == 2) begin
      clear_game();
      m_state = 0;
    end else if (m_state == 0) begin
      ok = 1'b1; any = 1'b0; m_nships = 0;
      tgt_x.delete(); tgt_y.delete();
      for (int x = 0; x < BD; x++) for (int y = 0; y < BD; y++) occ[x][y] = -1;
      for (int s = 0; s < NS; s++) begin
        if (s_len[s] > 0) begin
          any = 1'b1; m_nships++;
          for (int k = 0; k < s_len[s]; k++) begin
            cx = s_x[s] + (s_vert[s] != 0 ? 0 : k);
            cy = s_y[s] + (s_vert[s] != 0 ? k : 0);
            if (cx >= BD || cy >= BD) ok = 1'b0;
            else if (occ[cx][cy] != -1) ok = 1'b0;
            else begin occ[cx][cy] = s; tgt_x.push_back(cx); tgt_y.push_back(cy); end
          end
        end
      end
      if (ok && any) begin m_state = 1; m_cfg_err = 1'b0; end
      else m_cfg_err = 1'b1;
    end
  endtask

  task automatic model_shot(input int x, input int y, output res_t e);
    int s;
    e = '0;
    if (x >= BD || y >= BD) e.wrong = 1'b1;
    else if (shot_m[x][y]) begin
      e.rep = 1'b1;
      m_shots = (m_shots < 127) ? m_shots + 1 : 127;
    end else begin
      shot_m[x][y] = 1'b1;
      m_shots = (m_shots < 127) ? m_shots + 1 : 127;
      if (occ[x][y] >= 0) begin
        s = occ[x][y];
        e.hit = 1'b1;
        m_hits = (m_hits < 127) ? m_hits + 1 : 127;
        hit_per[s]++;
        if (hit_per[s] == s_len[s]) begin
          e.sunk = 1'b1; e.sidx = IW'(s);
          m_sunk++;
          if (s_len[s] > m_big) m_big = s_len[s];
          if (m_sunk == m_nships) m_state = 2;
        end
      end else if (occupied(x-1, y) || occupied(x+1, y) || occupied(x, y-1) || occupied(x, y+1))
        e.near = 1'b1;
      else e.miss = 1'b1;
    end
`ifdef BATTLESHIP_SHOT_LIMIT_EN
    if (!e.wrong && m_state == 1 && m_shots >= MS) m_state = 2;
`endif
    e.hits = 7'(m_hits); e.shots = SW'(m_shots); e.ships = (IW+1)'(m_sunk);
    e.big = 3'(m_big); e.over = (m_state == 2); e.ready = (m_state == 1);
  endtask

  // Drivers: each starts and ends on a falling edge.
  task automatic load_ship(input int idx, input int x, input int y, input int len, input int vert);
    ShipLoad = 1'b1; ShipIdx = IW'(idx); ShipX = CW'(x); ShipY = CW'(y);
    ShipLen = 3'(len); ShipVert = (vert != 0);
    if (m_state == 0) begin s_x[idx] = x; s_y[idx] = y; s_len[idx] = len; s_vert[idx] = vert; end
    @(negedge clock);
    ShipLoad = 1'b0;
  endtask

  task automatic do_start();
    Start = 1'b1;
    model_start();
    @(negedge clock);
    Start = 1'b0;
    check("config_error", ConfigError, m_cfg_err);
    check("ready_after_start", ShotReady, m_state == 1);
    check("gameover_after_start", GameOver, m_state == 2);
  endtask

  task automatic shoot(input int x, input int y);
    res_t e;
    if (m_state != 1) return;
    ShotValid = 1'b1; ShotX = CW'(x); ShotY = CW'(y);
    model_shot(x, y, e);
    exp_q.push_back(e);
    exp_t.push_back(pcyc + 1);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    ShotValid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  always @(posedge clock) pcyc <= pcyc + 1;

  // Monitor: pops the scoreboard whenever the DUT presents a result.
  always @(negedge clock) begin
    res_t a, e;
    int   t;
    if (reset_L && ResultValid) begin
      a = {Hit, NearMiss, Miss, Repeat, Wrong, Sunk, SunkIdx, NumHits, NumShots,
           ShipsSunk, BiggestShipSunk, GameOver, ShotReady};
      if (exp_q.size() == 0) check("unexpected_result", 1, 0);
      else begin
        e = exp_q.pop_front();
        t = exp_t.pop_front();
        check("result_latency", pcyc, t);
        check("result", a, e);
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, queue=%0d expected=0", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int x, y, r, tries, p;
    model_reset();
    repeat (3) @(negedge clock);
    check("reset_outputs", {ShotReady, ResultValid, Hit, NearMiss, Miss, Repeat, Wrong, Sunk,
          SunkIdx, NumHits, NumShots, ShipsSunk, BiggestShipSunk, ConfigError, GameOver}, 0);
    reset_L = 1'b1;
    @(negedge clock);

    // Overlapping fleet is rejected.
    load_ship(0, 2, 2, 3, 0);
    load_ship(1, 3, 1, 2, 1);
    do_start();
    check("overlap_cfg_error", ConfigError, 1);

    // Single two-cell ship sunk by two back-to-back hits.
    load_ship(1, 0, 0, 0, 0);
    load_ship(0, 0, 0, 2, 1);
    do_start();
    shoot(0, 0);
    shoot(0, 1);
    idle(2);
    do_start();

    // Classification of each kind, then a fourth scored shot.
    load_ship(0, 5, 5, 1, 0);
    do_start();
    shoot(5, 6);
    shoot(9, 9);
    shoot(9, 9);
    shoot(12, 0);
    idle(1);
    check("class_num_shots", NumShots, 3);
    check("class_num_hits", NumHits, 0);
    shoot(0, 0);
    shoot(5, 5);
    idle(2);
    if (m_state == 2) do_start();

    // Randomised fleets and shot streams.
    for (int g = 0; g < 6; g++) begin
      tries = 0;
      while (m_state == 0 && tries < 12) begin
        for (int s = 0; s < NS; s++)
          load_ship(s, $urandom_range(0, 9), $urandom_range(0, 9),
                    ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 5), $urandom_range(0, 1));
        do_start();
        tries++;
      end
      if (m_state == 0) begin
        for (int s = 0; s < NS; s++) load_ship(s, s * 2, 0, (s < 3) ? s + 1 : 0, 1);
        do_start();
      end
      load_ship(0, 9, 9, 7, 0);
      for (int n = 0; n < 200 && m_state == 1; n++) begin
        r = $urandom_range(0, 9);
        if (r < 6 && tgt_x.size() > 0) begin
          p = $urandom_range(0, tgt_x.size() - 1);
          x = tgt_x[p]; y = tgt_y[p];
        end else if (r < 9) begin
          x = $urandom_range(0, BD - 1); y = $urandom_range(0, BD - 1);
        end else begin
          x = $urandom_range(0, 15); y = $urandom_range(0, 15);
        end
        shoot(x, y);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      idle(2);
      if (m_state == 2) do_start();
    end

    // Asynchronous reset in PLAY with a result in flight.
    if (m_state == 0) begin
      for (int s = 0; s < NS; s++) load_ship(s, s * 2, 0, (s < 3) ? s + 1 : 0, 1);
      do_start();
    end
    shoot(9, 9);
    idle(1);
    ShotValid = 1'b1; ShotX = 4'd1; ShotY = 4'd1;
    @(posedge clock);
    #2;
    reset_L = 1'b0;
    ShotValid = 1'b0;
    #1;
    check("async_reset_outputs", {ShotReady, ResultValid, Hit, NearMiss, Miss, Repeat, Wrong, Sunk,
          SunkIdx, NumHits, NumShots, ShipsSunk, BiggestShipSunk, ConfigError, GameOver}, 0);
    model_reset();
    exp_q.delete();
    exp_t.delete();
    @(negedge clock);
    @(negedge clock);
    reset_L = 1'b1;
    @(negedge clock);
    check("ready_after_reset", ShotReady, 0);
    do_start();
    check("empty_fleet_after_reset", ConfigError, 1);

    idle(3);
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/battleship_scorer.md
Name: battleship_scorer

Overview:
- Sequential, parametrised successor of the combinational battleship shot scorer.
- Holds a loaded fleet of up to NUM_SHIPS ships on a BOARD_DIM x BOARD_DIM board and scores shots over a valid/ready handshake.
- Tracks the shot history, per-ship damage, sunk ships and game-over.
- Sits between the player-input front end and the score display.

Parameters:
BOARD_DIM, 10, board edge length; valid coordinates are 0..BOARD_DIM-1
COORD_W, 4, coordinate width; requires 2**COORD_W >= BOARD_DIM
NUM_SHIPS, 5, number of ship slots; IDX_W = $clog2(NUM_SHIPS), minimum 1
MAX_SHOTS, 50, shot budget; used only when BATTLESHIP_SHOT_LIMIT_EN is defined

Ports:
clock  in  1  system clock, rising edge
reset_L  in  1  asynchronous, active-low reset
ShipLoad  in  1  write one ship slot (honoured only in SETUP)
ShipIdx  in  IDX_W  slot to write
ShipX, ShipY  in  COORD_W each  bow coordinate
ShipLen  in  3  ship length 0..7; 0 marks the slot empty
ShipVert  in  1  1 = extends +Y, 0 = extends +X
Start  in  1  request to leave SETUP
ShotValid  in  1  shot offered
ShotX, ShotY  in  COORD_W each  shot coordinate
ShotReady  out  1  high only in PLAY
ResultValid  out  1  one-cycle pulse per accepted shot
Hit, NearMiss, Miss, Repeat, Wrong  out  1 each  result flags, qualified by ResultValid
Sunk  out  1  this shot completed a ship
SunkIdx  out  IDX_W  index of the ship that sank
NumHits  out  7  total distinct hits
NumShots  out  $clog2(BOARD_DIM*BOARD_DIM+1)  scored shots
ShipsSunk  out  IDX_W+1  ships sunk so far
BiggestShipSunk  out  3  length of the largest ship sunk
ConfigError  out  1  last Start was rejected
GameOver  out  1  high in DONE

Behaviour:
- Reset: state SETUP. All ship slots cleared to ShipLen=0. Shot bitmap and per-ship hit counters cleared. Every output is 0.
- FSM:
  - SETUP: ShipLoad writes the slot at the clock edge.
  - SETUP -> PLAY on Start, only if every non-empty ship lies fully on the board, no two ships share a cell, and at least one ship is non-empty. The move clears ConfigError.
  - Start that fails any check: stay in SETUP and set ConfigError=1. ConfigError holds until the next Start.
  - PLAY -> DONE when ShipsSunk equals the number of non-empty ships.
  - DONE -> SETUP on Start. This clears the bitmap, all counters and GameOver. Ship slots are kept.
  - ShipLoad outside SETUP is ignored.
- Handshake:
  - A shot is accepted when ShotValid && ShotReady.
  - Results are registered: ResultValid and the flags appear exactly 1 cycle after acceptance. One shot can be accepted per cycle with no bubbles.
- Classification of an accepted shot (exactly one flag set):
  - Wrong: ShotX or ShotY >= BOARD_DIM. No counter or bitmap change.
  - Repeat: the cell is already set in the bitmap. NumShots+1 only.
  - Hit: the cell is occupied by a ship. Set the bitmap bit, NumShots+1, NumHits+1, that ship's hit counter+1.
  - NearMiss: not occupied, but a 4-neighbour cell is occupied. Set the bitmap bit, NumShots+1.
  - Miss: otherwise. Set the bitmap bit, NumShots+1.
- Sunk: asserted with a Hit when the ship's hit counter reaches ShipLen. SunkIdx = that ship's index.
  - Same edge: ShipsSunk+1, and BiggestShipSunk = max(BiggestShipSunk, ShipLen).
  - If this is the last ship, GameOver rises on the same edge as ResultValid, and ShotReady drops.
- Counters saturate at their maximum value and never wrap.
- reset_L asserted mid-operation aborts immediately. Any pending result is discarded.

Optional Feature:
- Macro: BATTLESHIP_SHOT_LIMIT_EN.
- Defined: in PLAY, when NumShots reaches MAX_SHOTS on a scored shot, the FSM enters DONE on that edge with GameOver=1, even if ships remain. Sinking the last ship and reaching the limit on the same shot is a normal DONE.
- Undefined: there is no shot budget and MAX_SHOTS is unused.

Test Plan:
- Overlap check: load ship0 at (2,2) len 3 horizontal and ship1 at (3,1) len 2 vertical, then Start -> ConfigError=1, state stays SETUP, ShotReady=0.
- Sinking a ship: load ship0 at (0,0) len 2 vertical only, Start, shoot (0,0) -> Hit; shoot (0,1) -> Hit and Sunk with SunkIdx=0, ShipsSunk=1, BiggestShipSunk=2, GameOver=1, ShotReady=0.
- Classification: ship at (5,5) len 1; shoot (5,6) -> NearMiss; (9,9) -> Miss; (9,9) again -> Repeat; (12,0) -> Wrong. After these, NumShots=3 and NumHits=0.
- Back-to-back shots: ShotValid held for 4 cycles with different cells -> 4 consecutive ResultValid pulses, each 1 cycle after its acceptance.
- Async reset: assert reset_L low mid-PLAY between clock edges -> all outputs 0 immediately. After release the block is in SETUP with all ship slots empty.
- Shot limit: with BATTLESHIP_SHOT_LIMIT_EN defined and MAX_SHOTS=3, make 3 misses -> GameOver=1 after the third result. Without the macro, a 4th shot is accepted.
